// File: rtl/rca_add_sequencer.sv
// Byte-serial adder: one 8-bit ripple-carry adder is reused for every byte of a W-bit add.
// Optional subtraction support is compiled in with the RCA_SEQ_SUB_EN macro (adds port sub).

module Ripple_Carry_Adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[8];

endmodule

module rca_add_sequencer #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IdxW = $clog2(NBYTES);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e          state_q;
  logic [W-1:0]    a_q, b_q, res_q, res_d;
  logic [IdxW-1:0] idx_q;
  logic            carry_q;
  logic            sub_q;
  logic            first_carry;
  logic [7:0]      add_a, add_b, add_sum;
  logic            add_cout;

`ifdef RCA_SEQ_SUB_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q <= 1'b0;
    end else if (state_q == StIdle && start) begin
      sub_q <= sub;
    end
  end

  // Subtraction is a + ~b + 1, so the first carry is forced high.
  assign first_carry = sub ? 1'b1 : cin;
`else
  assign sub_q       = 1'b0;
  assign first_carry = cin;
`endif

  always_comb begin
    add_a = a_q[{idx_q, 3'b000} +: 8];
    add_b = b_q[{idx_q, 3'b000} +: 8] ^ {8{sub_q}};
    res_d = res_q;
    res_d[{idx_q, 3'b000} +: 8] = add_sum;
  end

  Ripple_Carry_Adder u_rca (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= first_carry;
            idx_q   <= '0;
            busy    <= 1'b1;
            state_q <= StAdd;
          end
        end
        StAdd: begin
          res_q   <= res_d;
          carry_q <= add_cout;
          idx_q   <= idx_q + 1'b1;
          // sum/cout only update here so partial bytes never show on the outputs.
          if (idx_q == IdxW'(NBYTES - 1)) begin
            sum     <= res_d;
            cout    <= add_cout;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/rca_add_sequencer.md
RCA_ADD_SEQUENCER -- requirements
Module: rca_add_sequencer

Interface
REQ-001 Parameter NBYTES, default 4, sets the operand width in bytes (W = 8*NBYTES); legal range is 2..16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request a new addition; sampled only in IDLE.
REQ-005 a  input  W  operand A, captured when start is accepted.
REQ-006 b  input  W  operand B, captured when start is accepted.
REQ-007 cin  input  1  carry-in, captured when start is accepted.
REQ-008 busy  output  1  high whenever state != IDLE.
REQ-009 done  output  1  one-cycle pulse that marks a valid sum/cout.
REQ-010 sum  output  W  registered result.
REQ-011 cout  output  1  registered carry out of the MSB byte.

Function
REQ-012 The block SHALL contain exactly one 8-bit Ripple_Carry_Adder instance (a, b, cin -> sum, cout) and SHALL use it for every byte; no other adders are allowed.
REQ-013 The FSM SHALL have three states: IDLE, ADD and DONE. Encoding is free.
REQ-014 IDLE with start=1 at edge E0 SHALL latch a, b and cin, clear the byte index to 0, and go to ADD.
REQ-015 At each ADD edge, the block SHALL:
- feed byte[idx] of A and B plus the carry register to the adder;
- store the 8-bit result into byte[idx] of an internal result register;
- load the adder cout into the carry register;
- increment idx.
REQ-016 The first ADD byte SHALL use the latched cin; each later byte SHALL use the carry from the previous byte.
REQ-017 At the edge that processes byte NBYTES-1 (edge E0+NBYTES), the block SHALL go to DONE and load sum (full result) and cout (final carry).
REQ-018 In DONE, done SHALL be 1 for exactly one cycle; the next edge SHALL return the FSM to IDLE.
REQ-019 Latency from the start-accept edge to done high SHALL be exactly NBYTES edges, with no stalls.
REQ-020 sum and cout SHALL hold their values from DONE until the next DONE; intermediate bytes SHALL never be visible on sum.
REQ-021 start in ADD or DONE SHALL be ignored. It SHALL NOT be queued, and a, b and cin changes during that time SHALL have no effect.
REQ-022 start held high continuously SHALL give back-to-back operations, each occupying NBYTES+2 cycles (accept, NBYTES adds, DONE).
REQ-023 Arithmetic SHALL be modulo 2^W; cout SHALL equal bit W of a+b+cin.

Reset
REQ-024 rst=1 at any edge SHALL force the following, overriding all other activity including mid-ADD: state=IDLE, idx=0, carry register=0, sum=0, cout=0, done=0, busy=0.
REQ-025 An operation aborted by reset SHALL produce no done pulse, and sum SHALL read 0.
REQ-026 start sampled in the same cycle as rst=1 SHALL be ignored.

Configuration
REQ-027 Macro RCA_SEQ_SUB_EN SHALL control subtraction support.
- Defined: the block SHALL add a 1-bit input port sub, latched with the operands. When the latched sub=1, every B byte SHALL be bit-inverted before the adder, the first-byte carry SHALL be 1 (cin ignored), the result SHALL be a-b mod 2^W, and cout=1 SHALL mean no borrow (a>=b unsigned).
- Undefined: port sub SHALL NOT exist, and only addition is supported.
REQ-028 Latency and handshake SHALL be identical with and without RCA_SEQ_SUB_EN.

Verification (NBYTES=4)
REQ-029 a=0xFFFFFFFF, b=0x00000001, cin=0, start at E0 -> done high after E4 only; sum=0x00000000, cout=1; busy high for E0..E5 (until the return to IDLE).
REQ-030 a=0x12345678, b=0x11111111, cin=1 -> sum=0x2345678A, cout=0. start pulsed again during ADD -> ignored, exactly one done pulse.
REQ-031 start held high for 3 operations (0x000000FF+0x00000001, 0x0000FFFF+0x00000001, 0xFFFFFFFF+0xFFFFFFFF) -> done pulses 6 cycles apart; sums 0x00000100, 0x00010000, 0xFFFFFFFE; couts 0, 0, 1.
REQ-032 rst asserted at E2 of an active operation -> no done pulse; sum=0, cout=0, busy=0 next cycle; a fresh start completes correctly.
REQ-033 With RCA_SEQ_SUB_EN and sub=1:
- a=0x00000005, b=0x00000007 -> sum=0xFFFFFFFE, cout=0;
- a=7, b=5 -> sum=0x00000002, cout=1.
REQ-034 Randomized check: 1000 random a, b, cin against the reference a+b+cin; every done pulse SHALL match on sum and cout.
